// File: rtl/lvdc_pio_pkg.sv
// rtl/lvdc_pio_pkg.sv - shared types and constants for the LVDC PIO sequencer
// Contents:
//   phase_t : bit-time phase slots W, X, Y, Z
//   state_t : sequencer FSM states
//   LVDC_WORD_BITS / LVDC_ADDR_BITS : default word and address widths
package lvdc_pio_pkg;

  localparam int LVDC_WORD_BITS = 26;
  localparam int LVDC_ADDR_BITS = 9;

  typedef enum logic [1:0] {
    PH_W,
    PH_X,
    PH_Y,
    PH_Z
  } phase_t;

  // Prefixed so the state names cannot collide with the top-level ADDR and
  // DONE ports once the package is wildcard-imported.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITW,
    S_ADDR,
    S_XFER,
    S_DONE
  } state_t;

endpackage

// File: rtl/lvdc_phase_gen.sv
// rtl/lvdc_phase_gen.sv - W/X/Y/Z bit-time phase generator with halt freeze
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   halt_req        : HALTV from the LVDA, only acted on at the end of Z
//   wda/xda/yda/zda : one-hot phases, all low in reset, before start and while halted
//   last_y          : high on the final clock of Y
//   last_z          : high on the clock whose edge starts the next W
//                     (end of Z without halt, or the resuming clock of a halt)
module lvdc_phase_gen
  import lvdc_pio_pkg::*;
#(
  parameter int PHASE_CLKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_req,
  output logic wda,
  output logic xda,
  output logic yda,
  output logic zda,
  output logic last_y,
  output logic last_z
);

  localparam int DW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PHASE_CLKS - 1);

  phase_t     phase;
  logic [DW-1:0] div;
  logic       running;  // clear in reset so the first edge afterwards raises W
  logic       halted;
  logic       active;
  logic       slot_end;
  logic       z_end;

  assign active   = running && !halted;
  assign slot_end = active && (div == DIV_LAST);
  assign z_end    = slot_end && (phase == PH_Z);
  assign last_y   = slot_end && (phase == PH_Y);
  // The bit-time boundary is deferred across a halt, so everything keyed on
  // last_z slips by exactly the number of halted clocks.
  assign last_z   = (z_end || halted) && !halt_req;

  assign wda = active && (phase == PH_W);
  assign xda = active && (phase == PH_X);
  assign yda = active && (phase == PH_Y);
  assign zda = active && (phase == PH_Z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= PH_W;
      div     <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (halted) begin
      if (!halt_req) halted <= 1'b0;
    end else if (slot_end) begin
      div   <= '0;
      phase <= phase_t'(phase + 2'd1);
      if (z_end && halt_req) halted <= 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/lvdc_pio_sequencer.sv
// rtl/lvdc_pio_sequencer.sv - LVDC process-I/O read sequencer feeding the LVDA
// Ports:
//   SIM_CLK, SIM_RST : clock, asynchronous active-high reset
//   REQ, ADDR        : read request and PIO address, sampled in IDLE
//   BUSY, DONE       : transfer in progress / one-clock completion pulse
//   RDATA            : assembled serial word, held until the next request
//   WDA..ZDA         : bit-time phases to the LVDA
//   AV, PIOV         : PIO address and strobe to the LVDA
//   DATAV, HALTV     : serial data and halt request from the LVDA
module lvdc_pio_sequencer
  import lvdc_pio_pkg::*;
#(
  parameter int WORD_BITS  = LVDC_WORD_BITS,
  parameter int ADDR_BITS  = LVDC_ADDR_BITS,
  parameter int PHASE_CLKS = 1
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 REQ,
  input  logic [ADDR_BITS-1:0] ADDR,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [WORD_BITS-1:0] RDATA,
  output logic                 WDA,
  output logic                 XDA,
  output logic                 YDA,
  output logic                 ZDA,
  output logic [ADDR_BITS-1:0] AV,
  output logic                 PIOV,
  input  logic                 DATAV,
  input  logic                 HALTV
);

  localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WORD_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_BITS-1:0] shift_q;
  logic [CW-1:0]        bit_cnt;
  logic                 last_y;
  logic                 last_z;

  lvdc_phase_gen #(
    .PHASE_CLKS(PHASE_CLKS)
  ) u_phase_gen (
    .clk     (SIM_CLK),
    .rst     (SIM_RST),
    .halt_req(HALTV),
    .wda     (WDA),
    .xda     (XDA),
    .yda     (YDA),
    .zda     (ZDA),
    .last_y  (last_y),
    .last_z  (last_z)
  );

  always_comb begin
    state_next = state;
    case (state)
      // A request landing on a bit-time boundary skips WAITW so ADDR starts
      // with the W that begins on that same edge.
      S_IDLE:  if (REQ) state_next = last_z ? S_ADDR : S_WAITW;
      S_WAITW: if (last_z) state_next = S_ADDR;
      S_ADDR:  if (last_z) state_next = S_XFER;
      S_XFER:  if (last_z && (bit_cnt == BIT_LAST)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && REQ) begin
        addr_q  <= ADDR;
        shift_q <= '0;
        bit_cnt <= '0;
      end
      if (state == S_XFER) begin
        if (last_y) shift_q <= {shift_q[WORD_BITS-2:0], DATAV};
        if (last_z && (bit_cnt != BIT_LAST)) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_DONE);
  assign PIOV  = (state == S_XFER);
  assign AV    = (state == S_ADDR || state == S_XFER) ? addr_q : '0;
  assign RDATA = shift_q;

endmodule

// File: tb/tb_lvdc_pio_sequencer.sv
// tb/tb_lvdc_pio_sequencer.sv - directed self-checking bench for lvdc_pio_sequencer
module tb_lvdc_pio_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [8:0]  addr = '0;
  logic        busy, done, wda, xda, yda, zda, piov;
  logic [25:0] rdata;
  logic [8:0]  av;
  logic        datav = 1'b0;
  logic        haltv = 1'b0;

  logic        req3 = 1'b0;
  logic [8:0]  addr3 = '0;
  logic        busy3, done3, wda3, xda3, yda3, zda3, piov3;
  logic [25:0] rdata3;
  logic [8:0]  av3;
  logic        datav3 = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lvdc_pio_sequencer #(.WORD_BITS(26), .ADDR_BITS(9), .PHASE_CLKS(1)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .REQ(req), .ADDR(addr), .BUSY(busy), .DONE(done),
    .RDATA(rdata), .WDA(wda), .XDA(xda), .YDA(yda), .ZDA(zda), .AV(av), .PIOV(piov),
    .DATAV(datav), .HALTV(haltv)
  );

  lvdc_pio_sequencer #(.WORD_BITS(26), .ADDR_BITS(9), .PHASE_CLKS(3)) dut3 (
    .SIM_CLK(clk), .SIM_RST(rst), .REQ(req3), .ADDR(addr3), .BUSY(busy3), .DONE(done3),
    .RDATA(rdata3), .WDA(wda3), .XDA(xda3), .YDA(yda3), .ZDA(zda3), .AV(av3), .PIOV(piov3),
    .DATAV(datav3), .HALTV(1'b0)
  );

  // LVDA-side data sources: present the next pattern bit for the whole Y
  // phase and its complement elsewhere, so a sample outside Y is visible.
  int          idx1 = -1;
  logic [25:0] pat1 = '0;
  logic        y1_last = 1'b0;
  logic        v1 = 1'b0;
  always @(negedge clk) begin
    if (piov && yda && !y1_last) begin
      v1 = (idx1 >= 0) ? pat1[idx1] : 1'b0;
      idx1 = idx1 - 1;
    end
    y1_last = yda;
    datav = yda ? v1 : ~v1;
  end

  int          idx3 = -1;
  logic [25:0] pat3 = '0;
  logic        y3_last = 1'b0;
  logic        v3 = 1'b0;
  always @(negedge clk) begin
    if (piov3 && yda3 && !y3_last) begin
      v3 = (idx3 >= 0) ? pat3[idx3] : 1'b0;
      idx3 = idx3 - 1;
    end
    y3_last = yda3;
    datav3 = yda3 ? v3 : ~v3;
  end

  // Stimulus/measurement for the PHASE_CLKS=1 instance: accept a request on
  // the last Z clock, then record per-clock observations. k counts clocks
  // after the accepting edge (k=0 is the first clock after it).
  task automatic run_xfer1(input logic [8:0] a, input logic [25:0] pat,
                           input int halt_k, input int halt_len, input int req2_k,
                           input int rst_k,
                           output int done_k, output int done_n, output int av_n,
                           output int piov_n, output int low_n, output logic busy0,
                           output logic busy_after, output logic [25:0] rd);
    bit found = 0;
    done_k = -1; done_n = 0; av_n = 0; piov_n = 0; low_n = 0;
    busy0 = 1'bx; busy_after = 1'bx; rd = 'x;
    pat1 = pat;
    idx1 = 25;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (zda) found = 1;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL align: no Z phase seen within 20 clocks");
      return;
    end
    req = 1'b1;
    addr = a;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      req = (k == req2_k);
      addr = (k == req2_k) ? 9'h1FF : a;
      haltv = (k >= halt_k) && (k < halt_k + halt_len);
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        return;
      end
      if (k == 0) busy0 = busy;
      if (av == a) av_n++;
      if (piov) piov_n++;
      if (!wda && !xda && !yda && !zda) low_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          rd = rdata;
        end
      end
      if (done_k >= 0 && k == done_k + 1) busy_after = busy;
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    req = 1'b0;
    haltv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({wda, xda, yda, zda} !== 4'b0000) begin errors++; $display("FAIL rst_phases: got %b want 0000", {wda, xda, yda, zda}); end
    checks++; if (av !== 9'h000) begin errors++; $display("FAIL rst_av: got %h want 000", av); end
    checks++; if ({piov, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {piov, busy, done}); end
    checks++; if (rdata !== 26'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++; if ({wda3, xda3, yda3, zda3} !== 4'b0000) begin errors++; $display("FAIL rst_phases3: got %b want 0000", {wda3, xda3, yda3, zda3}); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp;
      @(negedge clk);
      exp = 4'b1000 >> (i % 4);
      checks++; if ({wda, xda, yda, zda} !== exp) begin errors++; $display("FAIL idle_rotate[%0d]: got %b want %b", i, {wda, xda, yda, zda}, exp); end
    end
    checks++; if ({av, piov, busy, done} !== 12'h000) begin errors++; $display("FAIL idle_outputs: got av=%h piov=%b busy=%b done=%b want all 0", av, piov, busy, done); end
  endtask

  task automatic test_basic_read();
    int dk, dn, avn, pn, ln;
    logic b0, ba;
    logic [25:0] rd;
    run_xfer1(9'h0A5, 26'h2AAAAAA, -1, 0, -1, -1, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if (dk !== 108) begin errors++; $display("FAIL basic_done_at: got %0d want 108", dk); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_width: got %0d want 1", dn); end
    checks++; if (avn !== 108) begin errors++; $display("FAIL basic_av_clocks: got %0d want 108", avn); end
    checks++; if (pn !== 104) begin errors++; $display("FAIL basic_piov_clocks: got %0d want 104", pn); end
    checks++; if (rd !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_rdata: got %h want 2aaaaaa", rd); end
    checks++; if ({b0, ba} !== 2'b10) begin errors++; $display("FAIL basic_busy: got start=%b after=%b want 1 0", b0, ba); end
    checks++; if (rdata !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_rdata_hold: got %h want 2aaaaaa", rdata); end
  endtask

  task automatic test_halt_mid_xfer();
    int dk, dn, avn, pn, ln;
    logic b0, ba;
    logic [25:0] rd;
    // Z of XFER bit 10 is k = 4 + 4*10 + 3 = 47.
    run_xfer1(9'h0A5, 26'h2AAAAAA, 47, 20, -1, -1, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if (dk !== 128) begin errors++; $display("FAIL halt_done_at: got %0d want 128", dk); end
    checks++; if (ln !== 20) begin errors++; $display("FAIL halt_low_clocks: got %0d want 20", ln); end
    checks++; if (pn !== 124) begin errors++; $display("FAIL halt_piov_clocks: got %0d want 124", pn); end
    checks++; if (rd !== 26'h2AAAAAA) begin errors++; $display("FAIL halt_rdata: got %h want 2aaaaaa", rd); end
  endtask

  task automatic test_halt_ignored();
    int dk, dn, avn, pn, ln;
    logic b0, ba;
    logic [25:0] rd;
    // HALTV across W, X, Y of XFER bit 0 (k = 4..6), low again on its Z.
    run_xfer1(9'h155, 26'h3C0FF01, 4, 3, -1, -1, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if (dk !== 108 || ln !== 0) begin errors++; $display("FAIL halt_ignored: got done_at=%0d low=%0d want 108 0", dk, ln); end
    checks++; if (rd !== 26'h3C0FF01) begin errors++; $display("FAIL halt_ignored_rdata: got %h want 3c0ff01", rd); end
  endtask

  task automatic test_busy_reject();
    int dk, dn, avn, pn, ln;
    logic b0, ba;
    logic [25:0] rd;
    run_xfer1(9'h0A5, 26'h1234567, -1, 0, 50, -1, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if (avn !== 108) begin errors++; $display("FAIL busy_av_kept: got %0d clocks of 0a5 want 108", avn); end
    checks++; if (dn !== 1 || dk !== 108) begin errors++; $display("FAIL busy_single_done: got n=%0d at=%0d want 1 108", dn, dk); end
    checks++; if (rd !== 26'h1234567) begin errors++; $display("FAIL busy_rdata: got %h want 1234567", rd); end
  endtask

  task automatic test_reset_mid();
    int dk, dn, avn, pn, ln;
    logic b0, ba;
    logic [25:0] rd;
    int dseen = 0;
    // k = 25 is X of XFER bit 5; run_xfer1 raises SIM_RST there and returns 1 ns later.
    run_xfer1(9'h0A5, 26'h3FFFFFF, -1, 0, -1, 25, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if ({wda, xda, yda, zda, piov, busy, done} !== 7'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b want 0000000", {wda, xda, yda, zda, piov, busy, done}); end
    checks++; if (av !== 9'h000 || rdata !== 26'h0) begin errors++; $display("FAIL rstmid_data: got av=%h rdata=%h want 0 0", av, rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dseen); end
    run_xfer1(9'h033, 26'h0F0F0F0, -1, 0, -1, -1, dk, dn, avn, pn, ln, b0, ba, rd);
    checks++; if (dk !== 108 || rd !== 26'h0F0F0F0) begin errors++; $display("FAIL rstmid_fresh: got at=%0d rdata=%h want 108 0f0f0f0", dk, rd); end
  endtask

  task automatic test_phase3();
    int zc = 0;
    int dk = -1;
    bit found = 0;
    logic [25:0] rd = 'x;
    logic [3:0] ph2 = 'x, ph3 = 'x;
    pat3 = 26'h0000001;
    idx3 = 25;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      zc = zda3 ? zc + 1 : 0;
      if (zc == 3) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL p3_align: got no 3-clock Z phase want one"); end
    req3 = 1'b1;
    addr3 = 9'h0C3;
    @(posedge clk);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      req3 = 1'b0;
      if (k == 2) ph2 = {wda3, xda3, yda3, zda3};
      if (k == 3) ph3 = {wda3, xda3, yda3, zda3};
      if (done3 && dk < 0) begin
        dk = k;
        rd = rdata3;
        break;
      end
    end
    checks++; if (ph2 !== 4'b1000 || ph3 !== 4'b0100) begin errors++; $display("FAIL p3_phase_width: got k2=%b k3=%b want 1000 0100", ph2, ph3); end
    checks++; if (dk !== 324) begin errors++; $display("FAIL p3_done_at: got %0d want 324", dk); end
    checks++; if (rd !== 26'h0000001) begin errors++; $display("FAIL p3_rdata: got %h want 0000001", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_halt_mid_xfer();
    test_halt_ignored();
    test_busy_reject();
    test_reset_mid();
    test_phase3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvdc_pio_sequencer.md
# lvdc_pio_sequencer

Computer-side process-I/O sequencer that sits directly upstream of the LVDA. It generates the four bit-time clock phases (WDA/XDA/YDA/ZDA) that drive the LVDA timing, presents a 9-bit PIO address with the PIOV strobe, and shifts in the 26-bit serial word returned on DATAV into a parallel read register. It also honours HALTV from the LVDA by freezing the phase generator on a bit-time boundary.

## Interface
Parameters:
- WORD_BITS, 26, bits per transferred word (bit times in the XFER state)
- ADDR_BITS, 9, PIO address width
- PHASE_CLKS, 1, SIM_CLK cycles per clock phase (≥1)

Ports:
- SIM_CLK  in  1  sole clock; all state changes on its rising edge
- SIM_RST  in  1  reset, asynchronous, active-high
- REQ  in  1  start a PIO read; sampled only in IDLE
- ADDR  in  ADDR_BITS  PIO address; captured with REQ
- BUSY  out  1  high from REQ acceptance until the DONE pulse, inclusive
- DONE  out  1  one-SIM_CLK pulse when RDATA is valid
- RDATA  out  WORD_BITS  assembled word; held until the next accepted REQ
- WDA, XDA, YDA, ZDA  out  1 each  bit-time phases, one-hot or all-low
- AV  out  ADDR_BITS  AV[i-1] drives LVDA input AiV
- PIOV  out  1  PIO strobe to the LVDA
- DATAV  in  1  serial data from the LVDA
- HALTV  in  1  halt request from the LVDA

## Operation
- Phase generator: cycles W→X→Y→Z. Each phase lasts PHASE_CLKS clocks, so one bit time is 4×PHASE_CLKS clocks. Exactly one phase output is high, except during halt and reset, when all four are low.
- Halt: HALTV is sampled on the last clock of Z. If it is high, all phases go low and every counter freezes. On the first clock where HALTV is low, operation resumes with W. HALTV is ignored at every other point in the bit time.
- FSM states:
  - IDLE: REQ=1 latches ADDR, clears RDATA, sets BUSY, and moves to WAITW.
  - WAITW: move to ADDR at the next W start.
  - ADDR: drive AV with PIOV=0 for one full bit time, then move to XFER.
  - XFER: PIOV=1 and AV held for WORD_BITS bit times. DATAV is sampled on the last clock of Y and shifted in MSB-first (first sample ends in RDATA[WORD_BITS-1]). After the final Z, move to DONE.
  - DONE: DONE=1 and BUSY=1 for one clock, then return to IDLE.
- REQ in any state other than IDLE is ignored; no queuing.
- AV is 0 in IDLE. PIOV is high only in XFER.
- Bit counter width is clog2(WORD_BITS). It is compared against WORD_BITS-1 and never wraps mid-word.

## Timing
- Reset values: WDA=XDA=YDA=ZDA=0, AV=0, PIOV=0, BUSY=0, DONE=0, RDATA=0, FSM=IDLE, phase counter=W slot 0.
- On the first SIM_CLK edge after SIM_RST falls, WDA=1.
- Latency, with PHASE_CLKS=1 and REQ accepted on the last clock of Z:
  - ADDR starts on the next clock.
  - XFER starts 4 clocks later.
  - DONE is asserted 4+4×WORD_BITS = 108 clocks after acceptance.
- REQ accepted mid-bit-time: WAITW adds up to 4×PHASE_CLKS−1 clocks.
- A halt stretches latency by exactly the number of halted clocks. DONE is never asserted during a halt.
- SIM_RST mid-transfer: all outputs return to reset values immediately (asynchronously). No DONE is generated and the partial RDATA is discarded.
- If HALTV and the final XFER Z coincide, the halt takes effect first; DONE follows the first clock after resume.

## Structure
- Package lvdc_pio_pkg holds:
  - phase enum {PH_W, PH_X, PH_Y, PH_Z}
  - FSM state enum {IDLE, WAITW, ADDR, XFER, DONE}
  - constants LVDC_WORD_BITS=26, LVDC_ADDR_BITS=9
- Sub-module lvdc_phase_gen: phase counter, PHASE_CLKS divider and halt logic. Outputs the one-hot phases plus the strobes last_y and last_z.
- The top contains the FSM, bit counter, address register and shift register.

## Test plan
- Reset then idle: release SIM_RST → WDA,XDA,YDA,ZDA rotate with period 4; AV=0, PIOV=0, BUSY=0, RDATA=0.
- Basic read: ADDR=9'h0A5, REQ on last Z, DATAV driven from pattern 26'h2AAAAAA MSB-first on Y → AV=9'h0A5 for 108 clocks, PIOV high for 104, DONE pulse at clock 108, RDATA=26'h2AAAAAA.
- Halt mid-XFER: HALTV=1 on Z of bit 10 for 20 clocks → phases all low for 20 clocks, resume at W, DONE at clock 128, RDATA intact.
- Busy rejection: second REQ with ADDR=9'h1FF during XFER → ignored; AV stays 9'h0A5 and only one DONE.
- Reset mid-transfer: assert SIM_RST at bit 5 → all outputs 0 without waiting for a clock edge, no DONE; a fresh REQ after release completes normally.
- PHASE_CLKS=3: read of 26'h0000001 → each phase 3 clocks wide, DONE at 324 clocks, RDATA=26'h0000001.
